spi_master_core: RTL and testbench

- Byte-wide SPI master that consumes the SPI-side outputs of the APB register interface: write strobe, enable, TX byte, mode and clock divider.
- Returns busy and RX byte to that interface.
- Drives the off-chip SCLK/MOSI/CS_N pins and samples MISO.
- Runs entirely in the pclk_i domain; SCLK is derived by an integer divider.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_gen.sv | 26 ++
 rtl/spi_master_core.sv | 137 +++++++++++++
 tb/tb_spi_master_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master core.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_DIV_W  = 6;

    // Bit positions inside mode_i
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LEAD,
        XFER,
        TRAIL
    } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: pulses tick on the last cycle of every half-period while run is high.
module spi_clk_gen #(
    parameter int CNT_W = 7
) (
    input  logic             pclk_i,
    input  logic             prst_i,
    input  logic             run,
    input  logic [CNT_W-1:0] half,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == half - 1'b1);

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// Byte-wide SPI master: CPOL/CPHA modes, SCLK half-period = clk_div_i+1 pclk cycles.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV_W  = SPI_DIV_W
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic              write_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [1:0]        mode_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic              miso_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              done_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_n_o,
    output spi_state_t        dbg_state_o
);

    localparam int EC_W = $clog2(2 * DATA_W);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

    // Handshake: a rising edge of (write_i & enable_i) seen in IDLE starts one
    // transfer; busy_o stays high until the transfer ends, and done_o pulses in
    // the same cycle busy_o falls and rx_data_o updates. Edges while busy are dropped.

    spi_state_t         state;
    logic               req_d;
    logic [DATA_W-1:0]  tx_sr;
    logic [DATA_W-1:0]  rx_sr;
    logic [1:0]         mode_q;
    logic [DIV_W:0]     half_q;
    logic [EC_W-1:0]    edge_cnt;

    logic req;
    logic start;
    logic run;
    logic tick;
    logic lead_edge;
    logic sample_edge;

    assign req         = write_i & enable_i;
    assign start       = req & ~req_d;
    assign run         = (state == LEAD) || (state == XFER) || (state == TRAIL);
    assign lead_edge   = ~edge_cnt[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
    assign sample_edge = lead_edge ^ mode_q[CPHA_BIT];
    assign dbg_state_o = state;

    spi_clk_gen #(
        .CNT_W(DIV_W + 1)
    ) u_clk_gen (
        .pclk_i(pclk_i),
        .prst_i(prst_i),
        .run   (run),
        .half  (half_q),
        .tick  (tick)
    );

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state     <= IDLE;
            req_d     <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            mode_q    <= '0;
            half_q    <= '0;
            edge_cnt  <= '0;
            busy_o    <= 1'b0;
            rx_data_o <= '0;
            done_o    <= 1'b0;
            sclk_o    <= 1'b0;
            mosi_o    <= 1'b0;
            cs_n_o    <= 1'b1;
        end else begin
            req_d  <= req;
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_o <= mode_i[CPOL_BIT];
                    cs_n_o <= 1'b1;
                    mosi_o <= 1'b0;
                    busy_o <= 1'b0;
                    if (start) begin
                        busy_o <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    tx_sr    <= tx_data_i;
                    rx_sr    <= '0;
                    mode_q   <= mode_i;
                    half_q   <= {1'b0, clk_div_i} + 1'b1;
                    edge_cnt <= '0;
                    sclk_o   <= mode_i[CPOL_BIT];
                    cs_n_o   <= 1'b0;
                    mosi_o   <= mode_i[CPHA_BIT] ? 1'b0 : tx_data_i[DATA_W-1];
                    state    <= LEAD;
                end
                LEAD: begin
                    if (tick) state <= XFER;
                end
                XFER: begin
                    if (tick) begin
                        sclk_o   <= ~sclk_o;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], miso_i};
                        end else if (edge_cnt != LAST_EDGE) begin
                            mosi_o <= mode_q[CPHA_BIT] ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
                            tx_sr  <= tx_sr << 1;
                        end
                        if (edge_cnt == LAST_EDGE) state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        sclk_o    <= mode_q[CPOL_BIT];
                        cs_n_o    <= 1'b1;
                        mosi_o    <= 1'b0;
                        busy_o    <= 1'b0;
                        rx_data_o <= rx_sr;
                        done_o    <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Scoreboard bench for spi_master_core with a behavioural SPI slave model.
`timescale 1ns/1ps
module tb_spi_master_core;
    import spi_pkg::*;

    logic       pclk_i = 1'b0;
    logic       prst_i;
    logic       write_i;
    logic       enable_i;
    logic [7:0] tx_data_i;
    logic [1:0] mode_i;
    logic [5:0] clk_div_i;
    logic       miso_i;
    logic       busy_o;
    logic [7:0] rx_data_o;
    logic       done_o;
    logic       sclk_o;
    logic       mosi_o;
    logic       cs_n_o;
    spi_state_t dbg_state_o;

    spi_master_core #(.DATA_W(8), .DIV_W(6)) dut (
        .pclk_i     (pclk_i),
        .prst_i     (prst_i),
        .write_i    (write_i),
        .enable_i   (enable_i),
        .tx_data_i  (tx_data_i),
        .mode_i     (mode_i),
        .clk_div_i  (clk_div_i),
        .miso_i     (miso_i),
        .busy_o     (busy_o),
        .rx_data_o  (rx_data_o),
        .done_o     (done_o),
        .sclk_o     (sclk_o),
        .mosi_o     (mosi_o),
        .cs_n_o     (cs_n_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    always #5 pclk_i = ~pclk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues
    logic [7:0] exp_q[$];
    logic [7:0] exp_mosi_q[$];
    int         exp_len_q[$];
    int         done_seen = 0;
    int         xfers_expected = 0;

    // Slave model: shifts its byte out and captures mosi by SPI mode rules
    logic [1:0] cur_mode = 2'd0;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int         s_edges = 0;
    logic       miso_slave = 1'b0;
    logic       loopback = 1'b0;

    assign miso_i = loopback ? mosi_o : miso_slave;

    always @(negedge cs_n_o) begin
        s_edges = 0;
        s_rx    = 8'h00;
        if (!cur_mode[0]) begin
            miso_slave = s_tx[7];
            s_tx       = s_tx << 1;
        end
    end

    always @(sclk_o) begin
        if (!prst_i && cs_n_o === 1'b0) begin
            if ((sclk_o != cur_mode[1]) == (cur_mode[0] == 1'b0)) begin
                s_rx = {s_rx[6:0], mosi_o};
            end else begin
                miso_slave = s_tx[7];
                s_tx       = s_tx << 1;
            end
            s_edges++;
        end
    end

    // Monitor
    int busy_cnt = 0;
    int cs_cnt   = 0;

    always @(negedge pclk_i) begin
        if (prst_i) begin
            busy_cnt = 0;
            cs_cnt   = 0;
        end else begin
            if (busy_o === 1'b1) busy_cnt++;
            if (cs_n_o === 1'b0) cs_cnt++;
            if (done_o === 1'b1) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    check("rx_data", rx_data_o, exp_q.pop_front());
                    check("mosi_byte", s_rx, exp_mosi_q.pop_front());
                    begin
                        int len;
                        len = exp_len_q.pop_front();
                        check("busy_len", busy_cnt, len);
                        check("cs_low_len", cs_cnt, len - 1);
                    end
                    check("sclk_edges", s_edges, 16);
                    check("busy_at_done", busy_o, 0);
                    check("cs_at_done", cs_n_o, 1);
                end
                busy_cnt = 0;
                cs_cnt   = 0;
            end
        end
    end

    // Driver
    task automatic run_xfer(input logic [1:0] mode, input logic [5:0] div,
                            input logic [7:0] tx, input logic [7:0] sb, input logic loop,
                            input int hold, input bit mid_pulse,
                            input logic [1:0] nmode, input logic [5:0] ndiv);
        int h;
        bit got;
        h = int'(div) + 1;
        got = 1'b0;
        cur_mode  = mode;
        s_tx      = sb;
        loopback  = loop;
        mode_i    = mode;
        clk_div_i = div;
        tx_data_i = tx;
        exp_q.push_back(loop ? tx : sb);
        exp_mosi_q.push_back(tx);
        exp_len_q.push_back(1 + 18 * h);
        xfers_expected++;
        write_i  = 1'b1;
        enable_i = 1'b1;
        repeat (hold) @(negedge pclk_i);
        write_i  = 1'b0;
        enable_i = 1'b0;
        @(negedge pclk_i);
        tx_data_i = 8'($urandom);
        mode_i    = nmode;
        clk_div_i = ndiv;
        if (mid_pulse) begin
            @(negedge pclk_i);
            write_i  = 1'b1;
            enable_i = 1'b1;
            @(negedge pclk_i);
            write_i  = 1'b0;
            enable_i = 1'b0;
        end
        for (int k = 0; k < 1300 && !got; k++) begin
            @(negedge pclk_i);
            if (done_o === 1'b1) got = 1'b1;
        end
        check("done_timeout", got, 1);
        if (!got) begin
            exp_q.delete();
            exp_mosi_q.delete();
            exp_len_q.delete();
        end
        @(negedge pclk_i);
        check("idle_sclk", sclk_o, mode_i[1]);
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        int d0;
        bit got;
        prst_i    = 1'b1;
        write_i   = 1'b0;
        enable_i  = 1'b0;
        tx_data_i = 8'h00;
        mode_i    = 2'd0;
        clk_div_i = 6'd0;
        repeat (3) @(negedge pclk_i);
        check("rst_busy", busy_o, 0);
        check("rst_rx", rx_data_o, 0);
        check("rst_done", done_o, 0);
        check("rst_sclk", sclk_o, 0);
        check("rst_mosi", mosi_o, 0);
        check("rst_cs_n", cs_n_o, 1);
        check("rst_state", dbg_state_o, IDLE);
        prst_i = 1'b0;
        repeat (2) @(negedge pclk_i);

        // Directed mode cases
        run_xfer(2'd0, 6'd0, 8'hA5, 8'h3C, 1'b0, 1, 1'b0, 2'd0, 6'd0);
        run_xfer(2'd3, 6'd3, 8'h81, 8'h00, 1'b1, 1, 1'b0, 2'd3, 6'd3);
        run_xfer(2'd1, 6'd1, 8'h5A, 8'h00, 1'b1, 1, 1'b0, 2'd1, 6'd1);
        run_xfer(2'd2, 6'd2, 8'h5A, 8'h00, 1'b1, 1, 1'b0, 2'd2, 6'd2);
        run_xfer(2'd1, 6'd0, 8'h3C, 8'hC9, 1'b0, 1, 1'b0, 2'd1, 6'd0);
        // Held 2 cycles plus a dropped request mid-transfer
        run_xfer(2'd0, 6'd0, 8'hC3, 8'h96, 1'b0, 2, 1'b1, 2'd0, 6'd0);
        // Settings changed mid-transfer take effect only at the next LOAD
        run_xfer(2'd0, 6'd0, 8'h6E, 8'h1F, 1'b0, 1, 1'b0, 2'd2, 6'd5);
        // Largest divider
        run_xfer(2'd3, 6'd63, 8'hE7, 8'h42, 1'b0, 1, 1'b0, 2'd3, 6'd63);

        // Request held high across the whole transfer must not retrigger
        d0 = done_seen;
        mode_i    = 2'd0;
        clk_div_i = 6'd0;
        cur_mode  = 2'd0;
        tx_data_i = 8'h99;
        s_tx      = 8'h24;
        loopback  = 1'b0;
        exp_q.push_back(8'h24);
        exp_mosi_q.push_back(8'h99);
        exp_len_q.push_back(19);
        xfers_expected++;
        write_i  = 1'b1;
        enable_i = 1'b1;
        repeat (40) @(negedge pclk_i);
        write_i  = 1'b0;
        enable_i = 1'b0;
        repeat (25) @(negedge pclk_i);
        check("held_req_once", done_seen - d0, 1);
        check("held_req_busy", busy_o, 0);

        // write_i without enable_i is not a request
        d0 = done_seen;
        write_i = 1'b1;
        repeat (3) @(negedge pclk_i);
        write_i = 1'b0;
        repeat (25) @(negedge pclk_i);
        check("no_enable_done", done_seen - d0, 0);
        check("no_enable_busy", busy_o, 0);

        // Reset mid-transfer after the 7th SCLK edge
        mode_i    = 2'd0;
        clk_div_i = 6'd1;
        cur_mode  = 2'd0;
        tx_data_i = 8'hF0;
        s_tx      = 8'h0F;
        write_i   = 1'b1;
        enable_i  = 1'b1;
        @(negedge pclk_i);
        write_i  = 1'b0;
        enable_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge pclk_i);
            if (s_edges >= 7) got = 1'b1;
        end
        check("rst_mid_reach", got, 1);
        prst_i = 1'b1;
        #1;
        check("rst_mid_cs_n", cs_n_o, 1);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_rx", rx_data_o, 0);
        check("rst_mid_sclk", sclk_o, 0);
        check("rst_mid_state", dbg_state_o, IDLE);
        @(negedge pclk_i);
        prst_i = 1'b0;
        @(negedge pclk_i);
        run_xfer(2'd0, 6'd1, 8'h3D, 8'hB2, 1'b0, 1, 1'b0, 2'd0, 6'd1);

        // Randomized transfers
        for (int i = 0; i < 24; i++) begin
            run_xfer(2'($urandom), 6'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                     1'($urandom), $urandom_range(1, 3), 1'($urandom),
                     2'($urandom), 6'($urandom));
        end

        repeat (5) @(negedge pclk_i);
        check("done_count", done_seen, xfers_expected);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
